// File: rtl/norm_frame_sequencer_if.sv
// Stream/BRAM bundle for norm_frame_sequencer.
//   master : the sequencer (drives BRAM address and the pixel stream, sees ready and BRAM data)
//   slave  : the environment (BRAM model plus normalize stage)
// Signals:
//   rd_addr_out    BRAM read address (vcount*GRID_W + hcount)
//   rd_pixel_in    BRAM read data, fixed latency after the address
//   ready_in       downstream accepts the current pixel
//   pixel_out      pixel bit, hcount_out / vcount_out its coordinates
//   data_valid_out pixel_out / hcount_out / vcount_out valid
interface norm_frame_sequencer_if #(
  parameter int unsigned GRID_W = 32,
  parameter int unsigned GRID_H = 32
);
  localparam int unsigned HW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned VW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned AW = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;

  logic [AW-1:0] rd_addr_out;
  logic          rd_pixel_in;
  logic          ready_in;
  logic          pixel_out;
  logic [HW-1:0] hcount_out;
  logic [VW-1:0] vcount_out;
  logic          data_valid_out;

  modport master (
    output rd_addr_out,
    input  rd_pixel_in,
    input  ready_in,
    output pixel_out,
    output hcount_out,
    output vcount_out,
    output data_valid_out
  );

  modport slave (
    input  rd_addr_out,
    output rd_pixel_in,
    output ready_in,
    input  pixel_out,
    input  hcount_out,
    input  vcount_out,
    input  data_valid_out
  );
endinterface

// File: rtl/norm_frame_sequencer.sv
// norm_frame_sequencer: walks a GRID_W x GRID_H 1-bit frame buffer in raster order and streams
// each pixel with its coordinates to the normalize stage. Reads are credit-paced against a small
// output FIFO so a downstream stall never loses a pixel.
// Ports:
//   clk_in, rst_in   clock, synchronous active-high reset
//   start_in         pulse: begin a frame pass (accepted only in IDLE)
//   abort_in         only when NORM_SEQ_ABORT_EN is defined: abandon the current pass
//   busy_out         high from accepted start until the DONE cycle
//   done_out         one-cycle pulse after the last pixel has been handed off
//   frame_cnt_out    completed frames, wraps 255 -> 0
//   bus              master side of norm_frame_sequencer_if (BRAM address/data, pixel stream)
// Optional feature macro: NORM_SEQ_ABORT_EN adds abort_in.
module norm_frame_sequencer #(
  parameter int unsigned GRID_W   = 32,
  parameter int unsigned GRID_H   = 32,
  parameter int unsigned BRAM_LAT = 2
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
`ifdef NORM_SEQ_ABORT_EN
  input  logic       abort_in,
`endif
  output logic       busy_out,
  output logic       done_out,
  output logic [7:0] frame_cnt_out,
  norm_frame_sequencer_if.master bus
);
  localparam int unsigned HW = (GRID_W > 1) ? $clog2(GRID_W) : 1;
  localparam int unsigned VW = (GRID_H > 1) ? $clog2(GRID_H) : 1;
  localparam int unsigned AW = (GRID_W * GRID_H > 1) ? $clog2(GRID_W * GRID_H) : 1;
  localparam int unsigned D  = BRAM_LAT + 2;   // FIFO depth
  localparam int unsigned CW = $clog2(D + 1);  // credit / occupancy width
  localparam int unsigned PW = $clog2(D);      // FIFO pointer width

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  logic [CW-1:0]      r_credit;
  logic [BRAM_LAT-1:0] r_pipe_vld;
  logic [HW-1:0]      r_pipe_h [BRAM_LAT];
  logic [VW-1:0]      r_pipe_v [BRAM_LAT];
  logic               r_fifo_px [D];
  logic [HW-1:0]      r_fifo_h [D];
  logic [VW-1:0]      r_fifo_v [D];
  logic [PW-1:0]      r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [7:0]         r_frame_cnt;

  logic w_issue, w_busy, w_done, w_start, w_last, w_abort;
  logic w_push, w_pop, w_valid;

`ifdef NORM_SEQ_ABORT_EN
  assign w_abort = abort_in && ((r_state == StIssue) || (r_state == StDrain));
`else
  assign w_abort = 1'b0;
`endif

  assign w_start = (r_state == StIdle) && start_in;
  assign w_last  = (r_h == HW'(GRID_W - 1)) && (r_v == VW'(GRID_H - 1));
  assign w_push  = r_pipe_vld[BRAM_LAT-1];
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.ready_in;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // FSM: state register
  always_ff @(posedge clk_in) begin
    if (rst_in) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:  if (start_in) w_state_nxt = StIssue;
      StIssue: begin
        if (w_abort)               w_state_nxt = StIdle;
        else if (w_issue && w_last) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (w_abort)                             w_state_nxt = StIdle;
        else if (!w_valid && (r_pipe_vld == '0)) w_state_nxt = StDone;
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_issue = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    unique case (r_state)
      StIssue: begin
        w_busy  = 1'b1;
        w_issue = (r_credit != '0) && !w_abort;
      end
      StDrain: w_busy = 1'b1;
      StDone:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Raster counters; they hold on the last pixel so rd_addr_out keeps its value when idle.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_start) begin
      r_h <= '0;
      r_v <= '0;
    end else if (w_issue && !w_last) begin
      if (r_h == HW'(GRID_W - 1)) begin
        r_h <= '0;
        r_v <= r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
    end
  end

  // Credit = free FIFO slots not already claimed by reads in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_abort)      r_credit <= CW'(D);
    else if (w_issue && !w_pop) r_credit <= r_credit - CW'(1);
    else if (!w_issue && w_pop) r_credit <= r_credit + CW'(1);
  end

  // Coordinates travel alongside the BRAM read so they meet rd_pixel_in at the pipe tail.
  always_ff @(posedge clk_in) begin
    if (rst_in || w_abort) begin
      r_pipe_vld <= '0;
    end else begin
      r_pipe_vld[0] <= w_issue;
      for (int i = 1; i < BRAM_LAT; i++) r_pipe_vld[i] <= r_pipe_vld[i-1];
    end
  end

  always_ff @(posedge clk_in) begin
    r_pipe_h[0] <= r_h;
    r_pipe_v[0] <= r_v;
    for (int i = 1; i < BRAM_LAT; i++) begin
      r_pipe_h[i] <= r_pipe_h[i-1];
      r_pipe_v[i] <= r_pipe_v[i-1];
    end
  end

  // Output FIFO control
  always_ff @(posedge clk_in) begin
    if (rst_in || w_abort) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_fifo_px[r_wr_ptr] <= bus.rd_pixel_in;
      r_fifo_h[r_wr_ptr]  <= r_pipe_h[BRAM_LAT-1];
      r_fifo_v[r_wr_ptr]  <= r_pipe_v[BRAM_LAT-1];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in)                                         r_frame_cnt <= '0;
    else if ((r_state == StDrain) && (w_state_nxt == StDone)) r_frame_cnt <= r_frame_cnt + 8'd1;
  end

  // The credit scheme must keep every push away from a full FIFO.
  assert property (@(posedge clk_in) disable iff (rst_in) !(w_push && (r_count == CW'(D))));

  // General multiply-add form so non-power-of-2 widths map correctly.
  assign bus.rd_addr_out    = AW'(r_v) * AW'(GRID_W) + AW'(r_h);
  assign bus.data_valid_out = w_valid;
  // Head is gated by valid so stale FIFO contents never show after reset or abort.
  assign bus.pixel_out      = w_valid & r_fifo_px[r_rd_ptr];
  assign bus.hcount_out     = w_valid ? r_fifo_h[r_rd_ptr] : '0;
  assign bus.vcount_out     = w_valid ? r_fifo_v[r_rd_ptr] : '0;
  assign busy_out           = w_busy;
  assign done_out           = w_done;
  assign frame_cnt_out      = r_frame_cnt;
endmodule

// File: tb/tb_norm_frame_sequencer.sv
module tb_norm_frame_sequencer;
  localparam int unsigned W = 32, H = 32, LAT = 2, NPIX = W * H;
  localparam int unsigned SW = 6, SH = 5, SLAT = 3, SNPIX = SW * SH;

  typedef struct packed {logic px; logic [4:0] h; logic [4:0] v;} pix_t;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic       rst_in = 1'b1, start_in = 1'b0, abort_drv = 1'b0;
  logic       busy_out, done_out;
  logic [7:0] frame_cnt_out;
  logic       s_rst = 1'b1, s_start = 1'b0, s_abort = 1'b0;
  logic       s_busy, s_done;
  logic [7:0] s_fcnt;

  norm_frame_sequencer_if #(.GRID_W(W), .GRID_H(H)) bus ();
  norm_frame_sequencer_if #(.GRID_W(SW), .GRID_H(SH)) sbus ();

  norm_frame_sequencer #(.GRID_W(W), .GRID_H(H), .BRAM_LAT(LAT)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
`ifdef NORM_SEQ_ABORT_EN
    .abort_in      (abort_drv),
`endif
    .busy_out      (busy_out),
    .done_out      (done_out),
    .frame_cnt_out (frame_cnt_out),
    .bus           (bus)
  );

  // Small non-power-of-2 instance used for the frame-counter wrap run.
  norm_frame_sequencer #(.GRID_W(SW), .GRID_H(SH), .BRAM_LAT(SLAT)) dut_s (
    .clk_in        (clk_in),
    .rst_in        (s_rst),
    .start_in      (s_start),
`ifdef NORM_SEQ_ABORT_EN
    .abort_in      (s_abort),
`endif
    .busy_out      (s_busy),
    .done_out      (s_done),
    .frame_cnt_out (s_fcnt),
    .bus           (sbus)
  );

  // BRAM models: fixed read latency, no enable.
  logic       mem [NPIX];
  logic [9:0] a1 = '0, a2 = '0;
  always @(posedge clk_in) begin
    a1 <= bus.rd_addr_out;
    a2 <= a1;
  end
  assign bus.rd_pixel_in = mem[a2];

  logic       smem [32];
  logic [4:0] sa1 = '0, sa2 = '0, sa3 = '0;
  always @(posedge clk_in) begin
    sa1 <= sbus.rd_addr_out;
    sa2 <= sa1;
    sa3 <= sa2;
  end
  assign sbus.rd_pixel_in = smem[sa3];
  assign sbus.ready_in    = 1'b1;

  int   checks = 0, errors = 0;
  int   cyc = 0;
  pix_t exp_q[$];
  int   pix_seen = 0, done_cnt = 0, done_cyc = 0, first_valid_cyc = 0;
  bit   first_seen = 0;
  int   exp_done = 0, exp_frames = 0;
  int   s_idx = 0, s_dones = 0, s_done_cyc = 0;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // Monitor / scoreboard for the main instance.
  pix_t prev;
  bit   prev_stall = 0, prev_abort = 0;
  always @(negedge clk_in) begin
    pix_t e, a;
    if (rst_in) begin
      prev_stall = 0;
    end else begin
      a = {bus.pixel_out, bus.hcount_out, bus.vcount_out};
      if (prev_stall && !prev_abort) begin
        check("stall_valid_hold", bus.data_valid_out, 1);
        check("stall_data_hold", a, prev);
      end
      if (bus.data_valid_out && !first_seen) begin
        first_seen      = 1;
        first_valid_cyc = cyc;
      end
      if (bus.data_valid_out && bus.ready_in) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL extra_pixel: got px=%0d h=%0d v=%0d, required no pixel", a.px, a.h, a.v);
        end else begin
          e = exp_q.pop_front();
          if (a !== e) begin
            errors++;
            $display("FAIL pixel_%0d: got px=%0d h=%0d v=%0d, required px=%0d h=%0d v=%0d",
                     pix_seen, a.px, a.h, a.v, e.px, e.h, e.v);
          end
        end
        pix_seen++;
      end
      if (done_out) begin
        done_cnt++;
        done_cyc = cyc;
      end
      prev_stall = bus.data_valid_out && !bus.ready_in;
      prev       = a;
      prev_abort = abort_drv;
    end
  end

  // Checker for the small instance: raster order computed from the pixel index.
  always @(negedge clk_in) begin
    if (!s_rst) begin
      if (sbus.data_valid_out && sbus.ready_in) begin
        checks++;
        if ({sbus.pixel_out, sbus.hcount_out, sbus.vcount_out} !==
            {smem[s_idx], 3'(s_idx % SW), 3'(s_idx / SW)}) begin
          errors++;
          $display("FAIL s_pixel_%0d: got px=%0d h=%0d v=%0d, required px=%0d h=%0d v=%0d", s_idx,
                   sbus.pixel_out, sbus.hcount_out, sbus.vcount_out, smem[s_idx], s_idx % SW,
                   s_idx / SW);
        end
        s_idx++;
      end
      if (s_done) begin
        s_dones++;
        s_done_cyc = cyc;
      end
    end
  end

  // Fill the frame buffer and queue the expected raster stream, then pulse start.
  task automatic start_frame(input int pattern, output int t0);
    logic b;
    for (int v = 0; v < H; v++) begin
      for (int h = 0; h < W; h++) begin
        b = (pattern == 0) ? 1'((h ^ v) & 1) : 1'($urandom_range(0, 1));
        mem[v * W + h] = b;
        exp_q.push_back({b, 5'(h), 5'(v)});
      end
    end
    pix_seen   = 0;
    first_seen = 0;
    @(negedge clk_in);
    start_in = 1'b1;
    @(posedge clk_in);
    #1 start_in = 1'b0;
    t0 = cyc;
    @(negedge clk_in);
    check("busy_after_start", busy_out, 1);
  endtask

  task automatic wait_pix(input int target);
    int n = 0;
    while (pix_seen < target && n < 3000) begin
      @(posedge clk_in);
      #1 n++;
    end
    checks++;
    if (pix_seen < target) begin
      errors++;
      $display("FAIL wait_pixels: got %0d pixels, required %0d", pix_seen, target);
    end
  endtask

  // Runs a frame to done_out. poke: start pulses mid-frame and in the DONE cycle.
  // stall: ready low 10 cycles at pixel 100, then random ready.
  task automatic run_frame(input int pattern, input bit poke, input bit stall);
    int t0, base, n, hold;
    bit stalled;
    base = done_cnt; n = 0; hold = 0; stalled = 0;
    start_frame(pattern, t0);
    while (done_cnt == base && n < 5000) begin
      @(posedge clk_in);
      #1 n++;
      if (stall) begin
        if (!stalled && pix_seen >= 100) begin
          stalled = 1;
          hold    = 10;
        end
        if (hold > 0) begin
          bus.ready_in = 1'b0;
          hold--;
        end else if (stalled) begin
          bus.ready_in = ($urandom_range(0, 3) != 0);
        end
      end
      start_in = poke && (cyc == t0 + 50 || cyc == t0 + int'(NPIX + LAT + 2));
    end
    bus.ready_in = 1'b1;
    start_in     = 1'b0;
    exp_done++;
    exp_frames = (exp_frames + 1) % 256;
    check("done_count", done_cnt, exp_done);
    check("frame_cnt", frame_cnt_out, exp_frames);
    check("pixel_count", pix_seen, NPIX);
    check("queue_empty", exp_q.size(), 0);
    check("busy_after_done", busy_out, 0);
    if (!stall) begin
      check("latency_done", done_cyc - t0, NPIX + LAT + 2);
      check("latency_first", first_valid_cyc - t0, LAT + 1);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int st0, n, base;
    bus.ready_in = 1'b1;
    for (int i = 0; i < 32; i++) smem[i] = 1'((i % 3) == 0);
    repeat (3) @(posedge clk_in);
    #1 rst_in = 1'b0;
    s_rst = 1'b0;
    @(negedge clk_in);
    check("rst_valid", bus.data_valid_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_done", done_out, 0);
    check("rst_frame_cnt", frame_cnt_out, 0);
    check("rst_addr", bus.rd_addr_out, 0);
    check("rst_pixel_hv", {bus.pixel_out, bus.hcount_out, bus.vcount_out}, 0);

    // Checkerboard frame, timing and counter.
    run_frame(0, 0, 0);
    // Start pulses while busy and in the DONE cycle are ignored.
    run_frame(1, 1, 0);
    repeat (20) @(negedge clk_in);
    check("poke_idle_busy", busy_out, 0);
    check("poke_single_done", done_cnt, exp_done);
    // Stall and random back-pressure.
    run_frame(1, 0, 1);

    // Reset mid-frame.
    begin
      int t0;
      start_frame(1, t0);
    end
    wait_pix(500);
    rst_in = 1'b1;
    @(posedge clk_in);
    #1 rst_in = 1'b0;
    @(negedge clk_in);
    check("midrst_valid", bus.data_valid_out, 0);
    check("midrst_busy", busy_out, 0);
    check("midrst_done", done_out, 0);
    check("midrst_frame_cnt", frame_cnt_out, 0);
    check("midrst_addr", bus.rd_addr_out, 0);
    check("midrst_pixel_hv", {bus.pixel_out, bus.hcount_out, bus.vcount_out}, 0);
    exp_q.delete();
    exp_frames = 0;
    repeat (10) @(negedge clk_in);
    check("midrst_no_done", done_cnt, exp_done);
    check("midrst_quiet", bus.data_valid_out, 0);
    run_frame(1, 0, 0);

`ifdef NORM_SEQ_ABORT_EN
    begin
      int t0;
      start_frame(1, t0);
    end
    wait_pix(300);
    bus.ready_in = 1'b0;
    repeat (3) begin
      @(posedge clk_in);
      #1;
    end
    abort_drv = 1'b1;
    @(posedge clk_in);
    #1 abort_drv = 1'b0;
    @(negedge clk_in);
    check("abort_valid", bus.data_valid_out, 0);
    check("abort_busy", busy_out, 0);
    exp_q.delete();
    bus.ready_in = 1'b1;
    repeat (10) @(negedge clk_in);
    check("abort_no_done", done_cnt, exp_done);
    check("abort_frame_cnt", frame_cnt_out, exp_frames);
    check("abort_quiet", bus.data_valid_out, 0);
    run_frame(1, 0, 0);
`endif

    // 256 back-to-back frames on the small instance: frame counter wraps to 0.
    for (int f = 0; f < 256; f++) begin
      s_idx = 0;
      base  = s_dones;
      @(negedge clk_in);
      s_start = 1'b1;
      @(posedge clk_in);
      #1 s_start = 1'b0;
      st0 = cyc;
      n   = 0;
      while (s_dones == base && n < 200) begin
        @(posedge clk_in);
        #1 n++;
      end
      check("s_done", s_dones, base + 1);
      check("s_pixels", s_idx, SNPIX);
      check("s_frame_cnt", s_fcnt, (f + 1) % 256);
      if (f == 0) check("s_latency", s_done_cyc - st0, SNPIX + SLAT + 2);
    end
    check("s_total_done", s_dones, 256);
    check("s_wrap", s_fcnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
